// File: rtl/warp_fetch_scheduler.sv
// -----------------------------------------------------------------------------
// warp_fetch_scheduler
//
// Instruction-fetch sequencer for the SM front end. It keeps the active flag
// and PC of every warp. It picks the next warp round-robin, starting after the
// last granted warp. It issues one fetch at a time to the I-cache over a
// valid/ready handshake, and writes returned instructions into the per-warp
// instruction buffers.
//
// Ports
//   clk, rst_n          single clock; asynchronous active-low reset
//   launch_*_i          activate a warp at a start PC
//   exit_*_i            deactivate a warp
//   redirect_*_i        branch redirect: overwrite a warp's PC
//   ibuf_full_i         per-warp instruction buffer full (blocks selection only)
//   fetch_req_*         request channel to the I-cache (valid/ready)
//   fetch_rsp_*_i       I-cache response, one per accepted request
//   ibuf_wr_*_o         one-cycle write pulse into the target instruction buffer
//
// A warp counts as in flight from the edge that selects it until its response
// returns. A redirect or exit that hits the in-flight warp on any of those
// edges, including the selecting edge itself, squashes the response. The
// request is still completed on the bus, but the returned data is dropped.
// -----------------------------------------------------------------------------
module warp_fetch_scheduler #(
    parameter int NUM_WARP     = 4,
    parameter int NUM_WARP_LOG = 2,
    parameter int PC_WIDTH     = 32,
    parameter int INSTR_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    launch_valid_i,
    input  logic [NUM_WARP_LOG-1:0] launch_warp_i,
    input  logic [PC_WIDTH-1:0]     launch_pc_i,
    input  logic                    exit_valid_i,
    input  logic [NUM_WARP_LOG-1:0] exit_warp_i,
    input  logic                    redirect_valid_i,
    input  logic [NUM_WARP_LOG-1:0] redirect_warp_i,
    input  logic [PC_WIDTH-1:0]     redirect_pc_i,
    input  logic [NUM_WARP-1:0]     ibuf_full_i,
    output logic                    fetch_req_valid_o,
    input  logic                    fetch_req_ready_i,
    output logic [NUM_WARP_LOG-1:0] fetch_req_warp_o,
    output logic [PC_WIDTH-1:0]     fetch_req_pc_o,
    input  logic                    fetch_rsp_valid_i,
    input  logic [INSTR_WIDTH-1:0]  fetch_rsp_instr_i,
    output logic                    ibuf_wr_valid_o,
    output logic [NUM_WARP_LOG-1:0] ibuf_wr_warp_o,
    output logic [INSTR_WIDTH-1:0]  ibuf_wr_instr_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } fetchState_t;

    fetchState_t               state;
    logic [NUM_WARP-1:0]       active;
    logic [PC_WIDTH-1:0]       pcTable [NUM_WARP];
    logic                      squash;
    logic [NUM_WARP_LOG-1:0]   lastGrant;

    logic [NUM_WARP-1:0]       eligible;
    logic                      anyEligible;
    logic [NUM_WARP_LOG-1:0]   winner;
    logic [NUM_WARP_LOG-1:0]   trackedWarp;
    logic                      flightHit;

    // NOTE: every signal assigned in an always_comb block gets a default value
    // first, so that no path leaves it unassigned and infers a latch.
    always_comb begin
        eligible = active & ~ibuf_full_i;
        if (state != ST_IDLE) begin
            eligible[fetch_req_warp_o] = 1'b0;
        end
    end

    // Round-robin scan. The loop runs from the farthest offset to the
    // nearest, so the warp closest after lastGrant is written last and wins.
    // Offset NUM_WARP wraps back to lastGrant itself, which is checked last.
    always_comb begin
        anyEligible = 1'b0;
        winner      = lastGrant;
        for (int i = NUM_WARP; i >= 1; i--) begin
            if (eligible[lastGrant + NUM_WARP_LOG'(i)]) begin
                anyEligible = 1'b1;
                winner      = lastGrant + NUM_WARP_LOG'(i);
            end
        end
    end

    // In IDLE the warp that is about to become in flight is the winner.
    // Afterwards it is the latched request warp.
    always_comb begin
        trackedWarp = (state == ST_IDLE) ? winner : fetch_req_warp_o;
        flightHit   = (redirect_valid_i && (redirect_warp_i == trackedWarp)) ||
                      (exit_valid_i     && (exit_warp_i     == trackedWarp));
    end

    // NOTE: sequential state uses non-blocking assignments only. Later
    // assignments in this block to the same PC entry or active bit take
    // priority. That ordering gives launch priority over exit, and redirect
    // priority over the post-fetch increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            active            <= '0;
            squash            <= 1'b0;
            lastGrant         <= NUM_WARP_LOG'(NUM_WARP - 1);
            fetch_req_valid_o <= 1'b0;
            fetch_req_warp_o  <= '0;
            fetch_req_pc_o    <= '0;
            ibuf_wr_valid_o   <= 1'b0;
            ibuf_wr_warp_o    <= '0;
            ibuf_wr_instr_o   <= '0;
            // NOTE: the PC table is explicitly cleared on reset. It is a small
            // register file, not a RAM macro, and a relaunch must never
            // observe stale PCs.
            for (int w = 0; w < NUM_WARP; w++) begin
                pcTable[w] <= '0;
            end
        end else begin
            ibuf_wr_valid_o <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (anyEligible) begin
                        fetch_req_warp_o  <= winner;
                        fetch_req_pc_o    <= pcTable[winner];
                        fetch_req_valid_o <= 1'b1;
                        squash            <= flightHit;
                        state             <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    squash <= squash | flightHit;
                    if (fetch_req_ready_i) begin
                        lastGrant         <= fetch_req_warp_o;
                        fetch_req_valid_o <= 1'b0;
                        state             <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    squash <= squash | flightHit;
                    if (fetch_rsp_valid_i) begin
                        if (!(squash || flightHit)) begin
                            pcTable[fetch_req_warp_o] <= pcTable[fetch_req_warp_o] + PC_WIDTH'(4);
                            ibuf_wr_valid_o           <= 1'b1;
                            ibuf_wr_warp_o            <= fetch_req_warp_o;
                            ibuf_wr_instr_o           <= fetch_rsp_instr_i;
                        end
                        squash <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (exit_valid_i) begin
                active[exit_warp_i] <= 1'b0;
            end
            if (launch_valid_i) begin
                active[launch_warp_i]  <= 1'b1;
                pcTable[launch_warp_i] <= launch_pc_i;
            end
            if (redirect_valid_i) begin
                pcTable[redirect_warp_i] <= redirect_pc_i;
            end
        end
    end

endmodule

// File: tb/tb_warp_fetch_scheduler.sv
// -----------------------------------------------------------------------------
// tb_warp_fetch_scheduler
//
// Self-checking bench for warp_fetch_scheduler. A behavioural model tracks
// per-warp active/PC and the one outstanding fetch, and predicts the DUT
// outputs every cycle. Directed scenarios are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_warp_fetch_scheduler;

    localparam int NW  = 4;
    localparam int NWL = 2;
    localparam int PCW = 32;
    localparam int IW  = 32;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b1;
    logic           launch_valid_i;
    logic [NWL-1:0] launch_warp_i;
    logic [PCW-1:0] launch_pc_i;
    logic           exit_valid_i;
    logic [NWL-1:0] exit_warp_i;
    logic           redirect_valid_i;
    logic [NWL-1:0] redirect_warp_i;
    logic [PCW-1:0] redirect_pc_i;
    logic [NW-1:0]  ibuf_full_i;
    logic           fetch_req_valid_o;
    logic           fetch_req_ready_i;
    logic [NWL-1:0] fetch_req_warp_o;
    logic [PCW-1:0] fetch_req_pc_o;
    logic           fetch_rsp_valid_i;
    logic [IW-1:0]  fetch_rsp_instr_i;
    logic           ibuf_wr_valid_o;
    logic [NWL-1:0] ibuf_wr_warp_o;
    logic [IW-1:0]  ibuf_wr_instr_o;

    always #5 clk = ~clk;

    warp_fetch_scheduler #(
        .NUM_WARP(NW), .NUM_WARP_LOG(NWL), .PC_WIDTH(PCW), .INSTR_WIDTH(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .launch_valid_i(launch_valid_i), .launch_warp_i(launch_warp_i), .launch_pc_i(launch_pc_i),
        .exit_valid_i(exit_valid_i), .exit_warp_i(exit_warp_i),
        .redirect_valid_i(redirect_valid_i), .redirect_warp_i(redirect_warp_i),
        .redirect_pc_i(redirect_pc_i),
        .ibuf_full_i(ibuf_full_i),
        .fetch_req_valid_o(fetch_req_valid_o), .fetch_req_ready_i(fetch_req_ready_i),
        .fetch_req_warp_o(fetch_req_warp_o), .fetch_req_pc_o(fetch_req_pc_o),
        .fetch_rsp_valid_i(fetch_rsp_valid_i), .fetch_rsp_instr_i(fetch_rsp_instr_i),
        .ibuf_wr_valid_o(ibuf_wr_valid_o), .ibuf_wr_warp_o(ibuf_wr_warp_o),
        .ibuf_wr_instr_o(ibuf_wr_instr_o)
    );

    int numChecks = 0;
    int numErrors = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numErrors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Fetch phase: 0 = nothing outstanding, 1 = offered to the I-cache,
    // 2 = accepted and awaiting data.
    bit             mActive [NW];
    logic [PCW-1:0] mPc     [NW];
    int             mLastGrant;
    int             mPhase;
    int             mWarp;
    logic [PCW-1:0] mReqPc;
    bit             mDropData;
    bit             eWr;
    int             eWrWarp;
    logic [IW-1:0]  eWrInstr;
    int             grantLog[$];

    task automatic modelReset();
        for (int w = 0; w < NW; w++) begin
            mActive[w] = 1'b0;
            mPc[w]     = '0;
        end
        mLastGrant = NW - 1;
        mPhase     = 0;
        mWarp      = 0;
        mReqPc     = '0;
        mDropData  = 1'b0;
        eWr        = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic modelStep();
        int  winner;
        int  tgt;
        bit  hit;
        winner = -1;
        if (mPhase == 0) begin
            for (int k = 1; k <= NW; k++) begin
                int w;
                w = (mLastGrant + k) % NW;
                if (winner < 0 && mActive[w] && !ibuf_full_i[w]) winner = w;
            end
        end
        tgt = (mPhase == 0) ? winner : mWarp;
        hit = (tgt >= 0) &&
              ((redirect_valid_i && int'(redirect_warp_i) == tgt) ||
               (exit_valid_i && int'(exit_warp_i) == tgt));
        eWr = 1'b0;
        case (mPhase)
            0: if (winner >= 0) begin
                mPhase    = 1;
                mWarp     = winner;
                mReqPc    = mPc[winner];
                mDropData = hit;
            end
            1: begin
                mDropData = mDropData | hit;
                if (fetch_req_ready_i) begin
                    mLastGrant = mWarp;
                    mPhase     = 2;
                end
            end
            default: begin
                mDropData = mDropData | hit;
                if (fetch_rsp_valid_i) begin
                    if (!mDropData) begin
                        mPc[mWarp] = mPc[mWarp] + 32'd4;
                        eWr        = 1'b1;
                        eWrWarp    = mWarp;
                        eWrInstr   = fetch_rsp_instr_i;
                    end
                    mDropData = 1'b0;
                    mPhase    = 0;
                end
            end
        endcase
        if (exit_valid_i) mActive[exit_warp_i] = 1'b0;
        if (launch_valid_i) begin
            mActive[launch_warp_i] = 1'b1;
            mPc[launch_warp_i]     = launch_pc_i;
        end
        if (redirect_valid_i) mPc[redirect_warp_i] = redirect_pc_i;
    endtask

    task automatic checkOutputs();
        check("req_valid", fetch_req_valid_o, mPhase == 1);
        if (mPhase == 1) begin
            check("req_warp", fetch_req_warp_o, mWarp);
            check("req_pc", fetch_req_pc_o, mReqPc);
        end
        check("wr_valid", ibuf_wr_valid_o, eWr);
        if (eWr) begin
            check("wr_warp", ibuf_wr_warp_o, eWrWarp);
            check("wr_instr", ibuf_wr_instr_o, eWrInstr);
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        if (fetch_req_valid_o === 1'b1 && fetch_req_ready_i) grantLog.push_back(int'(fetch_req_warp_o));
        modelStep();
        @(negedge clk);
        checkOutputs();
    endtask

    task automatic clearIn();
        launch_valid_i    = 1'b0; launch_warp_i   = '0; launch_pc_i   = '0;
        exit_valid_i      = 1'b0; exit_warp_i     = '0;
        redirect_valid_i  = 1'b0; redirect_warp_i = '0; redirect_pc_i = '0;
        ibuf_full_i       = '0;
        fetch_req_ready_i = 1'b0;
        fetch_rsp_valid_i = 1'b0; fetch_rsp_instr_i = '0;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic doReset();
        rst_n = 1'b0;
        clearIn();
        #2;
        check("rst_req_valid", fetch_req_valid_o, 1'b0);
        check("rst_req_pc", fetch_req_pc_o, '0);
        check("rst_wr_valid", ibuf_wr_valid_o, 1'b0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic launch(input int w, input logic [PCW-1:0] pc, input logic [NW-1:0] full);
        clearIn();
        launch_valid_i = 1'b1; launch_warp_i = NWL'(w); launch_pc_i = pc;
        ibuf_full_i    = full;
        step();
    endtask

    // Launch all warps while their buffers are full, then free-run the
    // handshake and record the order of accepted requests.
    task automatic runGrants(input logic [NW-1:0] fullMask, input int nGrants);
        doReset();
        for (int w = 0; w < NW; w++) launch(w, PCW'(32'h1000 * w), '1);
        grantLog.delete();
        for (int c = 0; c < 40 && grantLog.size() < nGrants; c++) begin
            clearIn();
            ibuf_full_i = fullMask; fetch_req_ready_i = 1'b1;
            fetch_rsp_valid_i = 1'b1; fetch_rsp_instr_i = IW'(32'hA000 + c);
            step();
        end
        check("order_len", grantLog.size(), nGrants);
    endtask

    int orderA[5] = '{0, 1, 2, 3, 0};
    int orderB[4] = '{0, 1, 3, 0};

    initial begin
        clearIn();
        modelReset();
        @(negedge clk);
        doReset();

        // Basic fetch, PC increment and next request.
        launch(0, 32'h100, '0);
        clearIn(); fetch_req_ready_i = 1'b1; step();
        check("t1_valid", fetch_req_valid_o, 1'b1);
        check("t1_pc", fetch_req_pc_o, 32'h100);
        clearIn(); fetch_req_ready_i = 1'b1; step();
        clearIn(); step();
        clearIn(); fetch_rsp_valid_i = 1'b1; fetch_rsp_instr_i = 32'hCAFE_0001; step();
        check("t1_wr", ibuf_wr_valid_o, 1'b1);
        check("t1_instr", ibuf_wr_instr_o, 32'hCAFE_0001);
        clearIn(); step();
        check("t1_pc2", fetch_req_pc_o, 32'h104);

        // Round-robin order, with and without a full buffer.
        runGrants(4'b0000, 5);
        for (int i = 0; i < 5; i++)
            if (i < grantLog.size()) check("order_all", grantLog[i], orderA[i]);
        runGrants(4'b0100, 4);
        for (int i = 0; i < 4; i++)
            if (i < grantLog.size()) check("order_full2", grantLog[i], orderB[i]);

        // Back-pressure: request held stable for five cycles.
        doReset();
        launch(1, 32'h300, '0);
        clearIn(); step();
        for (int i = 0; i < 5; i++) begin
            clearIn(); step();
            check("hold_valid", fetch_req_valid_o, 1'b1);
            check("hold_warp", fetch_req_warp_o, 2'd1);
            check("hold_pc", fetch_req_pc_o, 32'h300);
        end
        clearIn(); fetch_req_ready_i = 1'b1; step();
        check("single_accept", fetch_req_valid_o, 1'b0);

        // Redirect while the warp waits for data: response dropped.
        clearIn(); redirect_valid_i = 1'b1; redirect_warp_i = 2'd1; redirect_pc_i = 32'h400; step();
        clearIn(); fetch_rsp_valid_i = 1'b1; fetch_rsp_instr_i = 32'hDEAD_0000; step();
        check("redir_drop", ibuf_wr_valid_o, 1'b0);
        clearIn(); step();
        check("redir_pc", fetch_req_pc_o, 32'h400);

        // Exit plus relaunch coinciding with the response.
        doReset();
        launch(0, 32'h500, '0);
        clearIn(); fetch_req_ready_i = 1'b1; step();
        clearIn(); fetch_req_ready_i = 1'b1; step();
        clearIn();
        exit_valid_i = 1'b1; exit_warp_i = 2'd0;
        launch_valid_i = 1'b1; launch_warp_i = 2'd0; launch_pc_i = 32'h200;
        fetch_rsp_valid_i = 1'b1; fetch_rsp_instr_i = 32'hBEEF_0000;
        step();
        check("exit_drop", ibuf_wr_valid_o, 1'b0);
        clearIn(); step();
        check("relaunch_valid", fetch_req_valid_o, 1'b1);
        check("relaunch_pc", fetch_req_pc_o, 32'h200);

        // Reset while a request is pending; a late response is ignored.
        doReset();
        clearIn(); fetch_rsp_valid_i = 1'b1; fetch_rsp_instr_i = 32'h1234_5678; step();
        check("late_rsp", ibuf_wr_valid_o, 1'b0);
        launch(3, 32'h700, '0);
        clearIn(); step();
        check("resume_warp", fetch_req_warp_o, 2'd3);
        check("resume_pc", fetch_req_pc_o, 32'h700);

        // Randomized traffic, with an occasional asynchronous reset.
        for (int c = 0; c < 4000; c++) begin
            if (c % 1000 == 999) doReset();
            clearIn();
            launch_valid_i    = ($urandom_range(0, 7) == 0);
            launch_warp_i     = NWL'($urandom_range(0, NW - 1));
            launch_pc_i       = $urandom & 32'hFFFF_FFFC;
            exit_valid_i      = ($urandom_range(0, 15) == 0);
            exit_warp_i       = NWL'($urandom_range(0, NW - 1));
            redirect_valid_i  = ($urandom_range(0, 7) == 0);
            redirect_warp_i   = NWL'($urandom_range(0, NW - 1));
            redirect_pc_i     = (c % 500 == 7) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            ibuf_full_i       = NW'($urandom_range(0, 15) & $urandom_range(0, 15));
            fetch_req_ready_i = ($urandom_range(0, 2) != 0);
            fetch_rsp_valid_i = ($urandom_range(0, 4) < 2);
            fetch_rsp_instr_i = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule
